// File: rtl/alu_pkg.sv
// Shared definitions for the KLP32 sequential ALU: op codes, FSM states,
// and the legality check for base (non-M) operations.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_PASS = 4'b1111;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_e;

  // True only for the eleven defined base op codes with the M group bit clear.
  function automatic logic is_base_legal(input logic [4:0] sel);
    logic ok;
    ok = 1'b0;
    if (!sel[4]) begin
      case (sel[3:0])
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
        OP_SRL, OP_SRA, OP_OR, OP_AND, OP_PASS: ok = 1'b1;
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative radix-2 multiply/divide for alu_seq (only built with ALU_MULDIV_EN).
// Operands are reduced to magnitudes on start; a single 2*XLEN accumulator is
// used as {hi, multiplier} for shift-add multiply and {rem, quotient} for
// restoring divide. Signs are reapplied on the last iteration, so result_o is
// valid combinationally in the cycle done_o is high.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] x_i,
  input  logic [XLEN-1:0] y_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              negp_q, negp_d;   // negate product / quotient
  logic              negr_q, negr_d;   // negate remainder (dividend sign)
  logic              dz_q, dz_d;       // divide by zero
  logic [XLEN-1:0]   b_q, b_d;         // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] acc_q, acc_d;

  logic              x_s, y_s, xs, ys;
  logic [XLEN-1:0]   x_mag, y_mag;
  logic [XLEN:0]     sum, trial;
  logic [2*XLEN-1:0] step_acc, prod;
  logic [XLEN-1:0]   quo, rem;

  // Operand sign handling on start and one accumulator iteration per cycle.
  always_comb begin
    x_s   = (op_i == MD_MULH) | (op_i == MD_MULHSU) | (op_i == MD_DIV) | (op_i == MD_REM);
    y_s   = (op_i == MD_MULH) | (op_i == MD_DIV) | (op_i == MD_REM);
    xs    = x_s & x_i[XLEN-1];
    ys    = y_s & y_i[XLEN-1];
    x_mag = xs ? -x_i : x_i;
    y_mag = ys ? -y_i : y_i;

    sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, b_q};
    // Shifted remainder is < 2*divisor, so a clear top bit means "fits".
    trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
    if (!op_q[2]) begin
      step_acc = acc_q[0] ? {sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
    end else begin
      step_acc = trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                             : {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end

    busy_d = busy_q;
    cnt_d  = cnt_q;
    op_d   = op_q;
    negp_d = negp_q;
    negr_d = negr_q;
    dz_d   = dz_q;
    b_d    = b_q;
    acc_d  = acc_q;
    if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      op_d   = op_i;
      negp_d = xs ^ ys;
      negr_d = xs;
      dz_d   = (y_i == '0);
      if (op_i[2]) begin
        b_d   = y_mag;
        acc_d = {{XLEN{1'b0}}, x_mag};
      end else begin
        b_d   = x_mag;
        acc_d = {{XLEN{1'b0}}, y_mag};
      end
    end else if (busy_q) begin
      acc_d = step_acc;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end
    end
  end

  // Final sign fix-up from the last iteration's accumulator.
  always_comb begin
    prod = negp_q ? -step_acc : step_acc;
    quo  = step_acc[XLEN-1:0];
    rem  = step_acc[2*XLEN-1:XLEN];
    case (op_q)
      MD_MUL:                       result_o = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result_o = prod[2*XLEN-1:XLEN];
      // Signed /0 must give all-ones regardless of the dividend sign.
      MD_DIV:                       result_o = dz_q ? '1 : (negp_q ? -quo : quo);
      MD_DIVU:                      result_o = quo;
      MD_REM:                       result_o = negr_q ? -rem : rem;
      default:                      result_o = rem;
    endcase
  end

  assign busy_o = busy_q;
  assign done_o = busy_q & (cnt_q == CNT_LAST);

  // Iteration state; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      op_q   <= '0;
      negp_q <= 1'b0;
      negr_q <= 1'b0;
      dz_q   <= 1'b0;
      b_q    <= '0;
      acc_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      negp_q <= negp_d;
      negr_q <= negr_d;
      dz_q   <= dz_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked, registered ALU for the KLP32 execute stage.
// Base ops complete in one edge; with ALU_MULDIV_EN defined, sel[4]=1 starts
// the iterative M-extension unit (XLEN cycles in BUSY). Without the macro any
// sel[4]=1 op completes in one edge as illegal with a zero result.
module alu_seq
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_x,
  input  logic [XLEN-1:0] in_y,
  input  logic [4:0]      in_sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_illegal
);

  localparam int SHAMT_W = $clog2(XLEN);

  state_e          state_q, state_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            ill_q, ill_d;
  logic            accept, is_md, base_ok;
  logic [XLEN-1:0] base_res;
  logic [SHAMT_W-1:0] shamt;

  assign in_ready    = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
  assign accept      = in_valid & in_ready;
  assign out_valid   = (state_q == ST_DONE);
  assign out_result  = res_q;
  assign out_illegal = ill_q;
  assign shamt       = in_y[SHAMT_W-1:0];
  assign base_ok     = is_base_legal(in_sel);

`ifdef ALU_MULDIV_EN
  logic            md_busy, md_done;
  logic [XLEN-1:0] md_result;

  assign is_md = in_sel[4];

  muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (accept & is_md),
    .op_i     (in_sel[2:0]),
    .x_i      (in_x),
    .y_i      (in_y),
    .busy_o   (md_busy),
    .done_o   (md_done),
    .result_o (md_result)
  );
`else
  assign is_md = 1'b0;
`endif

  // Single-cycle base datapath, evaluated on the operands being accepted.
  always_comb begin
    base_res = '0;
    case (in_sel[3:0])
      OP_ADD:  base_res = in_x + in_y;
      OP_SUB:  base_res = in_x - in_y;
      OP_SLL:  base_res = in_x << shamt;
      OP_SLT:  base_res[0] = ($signed(in_x) < $signed(in_y));
      OP_SLTU: base_res[0] = (in_x < in_y);
      OP_XOR:  base_res = in_x ^ in_y;
      OP_SRL:  base_res = in_x >> shamt;
      OP_SRA:  base_res = $unsigned($signed(in_x) >>> shamt);
      OP_OR:   base_res = in_x | in_y;
      OP_AND:  base_res = in_x & in_y;
      OP_PASS: base_res = in_y;
      default: base_res = '0;
    endcase
  end

  // Handshake FSM and result register; the result only changes on a
  // new accept or an M-unit completion, so it is stable under backpressure.
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    ill_d   = ill_q;
    if (accept) begin
      if (is_md) begin
        state_d = ST_BUSY;
      end else begin
        state_d = ST_DONE;
        res_d   = base_ok ? base_res : '0;
        ill_d   = ~base_ok;
      end
    end else if ((state_q == ST_DONE) && out_ready) begin
      state_d = ST_IDLE;
    end
`ifdef ALU_MULDIV_EN
    if ((state_q == ST_BUSY) && md_busy && md_done) begin
      state_d = ST_DONE;
      res_d   = md_result;
      ill_d   = 1'b0;
    end
`endif
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      res_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      ill_q   <= ill_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at XLEN=32 and XLEN=64.
// M-extension vectors are exercised only when ALU_MULDIV_EN is defined.
module tb_alu_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        iv, ir, ov, ordy, oill;
  logic [31:0] x, y, res;
  logic [4:0]  sel;

  logic        iv6, ir6, ov6, ordy6, oill6;
  logic [63:0] x6, y6, res6;
  logic [4:0]  sel6;

  alu_seq #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .in_x(x), .in_y(y),
    .in_sel(sel), .out_valid(ov), .out_ready(ordy), .out_result(res), .out_illegal(oill));

  alu_seq #(.XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv6), .in_ready(ir6), .in_x(x6), .in_y(y6),
    .in_sel(sel6), .out_valid(ov6), .out_ready(ordy6), .out_result(res6), .out_illegal(oill6));

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [4:0]  sel;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] res;
    logic        ill;
    int          lat;
  } vec_t;
  vec_t vt[$];

`ifdef ALU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic [4:0] s, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input logic il, input int lat);
    vec_t v;
    v.sel = s; v.x = a; v.y = b; v.res = r; v.ill = il; v.lat = lat;
    vt.push_back(v);
  endtask

  // Present one op, count edges (accept edge = 1) until out_valid, then drain.
  task automatic run32(input logic [4:0] s, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic il, output int lat);
    sel = s; x = a; y = b; iv = 1'b1; ordy = 1'b1;
    step();
    iv = 1'b0; lat = 1;
    while (!ov && lat < 200) begin step(); lat++; end
    r = res; il = oill;
    step();
  endtask

  task automatic run64(input logic [4:0] s, input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] r, output logic il, output int lat);
    sel6 = s; x6 = a; y6 = b; iv6 = 1'b1; ordy6 = 1'b1;
    step();
    iv6 = 1'b0; lat = 1;
    while (!ov6 && lat < 200) begin step(); lat++; end
    r = res6; il = oill6;
    step();
  endtask

  // Behavioural reference for XLEN=64: {illegal, result}.
  function automatic logic [64:0] model64(input logic [4:0] s, input logic [63:0] a,
                                          input logic [63:0] b);
    logic [127:0] p;
    logic [63:0]  r;
    logic         il;
    logic         ovf;
    il  = 1'b0;
    r   = '0;
    p   = '0;
    ovf = (a == 64'h8000_0000_0000_0000) && (b == '1);
    casez (s)
      5'b00000: r = a + b;
      5'b01000: r = a - b;
      5'b00001: r = a << b[5:0];
      5'b00010: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      5'b00011: r = (a < b) ? 64'd1 : 64'd0;
      5'b00100: r = a ^ b;
      5'b00101: r = a >> b[5:0];
      5'b01101: r = $signed(a) >>> b[5:0];
      5'b00110: r = a | b;
      5'b00111: r = a & b;
      5'b01111: r = b;
      5'b1?000: if (MD) r = a * b; else il = 1'b1;
      5'b1?001: if (MD) begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
                else il = 1'b1;
      5'b1?010: if (MD) begin p = {{64{a[63]}}, a} * {64'd0, b}; r = p[127:64]; end
                else il = 1'b1;
      5'b1?011: if (MD) begin p = {64'd0, a} * {64'd0, b}; r = p[127:64]; end
                else il = 1'b1;
      5'b1?100: if (MD) r = (b == 0) ? '1 : ovf ? a : $signed(a) / $signed(b); else il = 1'b1;
      5'b1?101: if (MD) r = (b == 0) ? '1 : a / b; else il = 1'b1;
      5'b1?110: if (MD) r = (b == 0) ? a : ovf ? 64'd0 : $signed(a) % $signed(b); else il = 1'b1;
      5'b1?111: if (MD) r = (b == 0) ? a : a % b; else il = 1'b1;
      default:  il = 1'b1;
    endcase
    return {il, r};
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic        il;
    int          lat;
    logic [63:0] r6, a6, b6;
    logic        il6;
    logic [64:0] m;
    logic [4:0]  ops[$];
    logic [4:0]  s;
    int          seen;
    int          mlat;

    iv = 0; ordy = 1; x = 0; y = 0; sel = 0;
    iv6 = 0; ordy6 = 1; x6 = 0; y6 = 0; sel6 = 0;
    mlat = MD ? 33 : 1;

    // Reset state
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("reset out_valid", ov, 0);
    chk("reset out_result", res, 0);
    chk("reset out_illegal", oill, 0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("reset in_ready", ir, 1);

    // Reset while holding a result under backpressure
    sel = {1'b0, OP_ADD}; x = 5; y = 6; iv = 1; ordy = 0;
    step();
    iv = 0;
    chk("held valid", ov, 1);
    chk("held result", res, 11);
    rst_n = 1'b0;
    #1;
    chk("async reset valid", ov, 0);
    chk("async reset result", res, 0);
    step();
    rst_n = 1'b1; ordy = 1;
    step();
    chk("post reset in_ready", ir, 1);

    // Directed vector table
    add_vec(5'b00000, 32'd10, 32'd20, 32'd30, 0, 1);
    add_vec(5'b01000, 32'd50, 32'd30, 32'd20, 0, 1);
    add_vec(5'b01101, 32'hFFFF_FFF0, 32'd1, 32'hFFFF_FFF8, 0, 1);
    add_vec(5'b00011, 32'd1, 32'hFFFF_FFFF, 32'd1, 0, 1);
    add_vec(5'b01111, 32'd0, 32'd7, 32'd7, 0, 1);
    add_vec(5'b00010, 32'hFFFF_FFFF, 32'd1, 32'd1, 0, 1);
    add_vec(5'b00010, 32'd1, 32'hFFFF_FFFF, 32'd0, 0, 1);
    add_vec(5'b00001, 32'd1, 32'd33, 32'd2, 0, 1);
    add_vec(5'b00101, 32'h8000_0000, 32'd31, 32'd1, 0, 1);
    add_vec(5'b01101, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 0, 1);
    add_vec(5'b00100, 32'hF0F0, 32'hFF00, 32'h0FF0, 0, 1);
    add_vec(5'b00110, 32'hF0F0, 32'hFF00, 32'hFFF0, 0, 1);
    add_vec(5'b00111, 32'hF0F0, 32'hFF00, 32'hF000, 0, 1);
    add_vec(5'b00000, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 1);
    add_vec(5'b01001, 32'd1, 32'd2, 32'd0, 1, 1);
    add_vec(5'b01010, 32'd3, 32'd4, 32'd0, 1, 1);
    add_vec(5'b01110, 32'd3, 32'd4, 32'd0, 1, 1);
    if (MD) begin
      add_vec(5'b10000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, mlat);
      add_vec(5'b11000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, mlat);
      add_vec(5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, mlat);
      add_vec(5'b10001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 0, mlat);
      add_vec(5'b10010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, mlat);
      add_vec(5'b10100, 32'd7, 32'd0, 32'hFFFF_FFFF, 0, mlat);
      add_vec(5'b10110, 32'd7, 32'd0, 32'd7, 0, mlat);
      add_vec(5'b10100, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 0, mlat);
      add_vec(5'b10110, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 0, mlat);
      add_vec(5'b10101, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, mlat);
      add_vec(5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, mlat);
      add_vec(5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, mlat);
      add_vec(5'b10101, 32'd100, 32'd7, 32'd14, 0, mlat);
      add_vec(5'b10111, 32'd100, 32'd7, 32'd2, 0, mlat);
      add_vec(5'b10100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, mlat);
      add_vec(5'b10110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, mlat);
    end else begin
      add_vec(5'b10000, 32'd7, 32'd3, 32'd0, 1, 1);
      add_vec(5'b10100, 32'd7, 32'd0, 32'd0, 1, 1);
    end

    foreach (vt[i]) begin
      run32(vt[i].sel, vt[i].x, vt[i].y, r, il, lat);
      chk($sformatf("vec%0d sel=%b result", i, vt[i].sel), r, vt[i].res);
      chk($sformatf("vec%0d illegal", i), il, vt[i].ill);
      chk($sformatf("vec%0d latency", i), lat, vt[i].lat);
    end

    // M op in flight: in_ready low while busy; reset discards it
    if (MD) begin
      sel = 5'b10000; x = 3; y = 4; iv = 1; ordy = 1;
      step();
      iv = 0;
      chk("busy in_ready", ir, 0);
      repeat (5) step();
      rst_n = 1'b0;
      #1;
      chk("busy reset valid", ov, 0);
      chk("busy reset result", res, 0);
      step();
      rst_n = 1'b1;
      seen = 0;
      repeat (40) begin step(); if (ov) seen++; end
      chk("no partial result after reset", seen, 0);
      chk("idle after busy reset", ir, 1);
    end

    // Backpressure: result held, new op not accepted until out_ready
    sel = {1'b0, OP_ADD}; x = 3; y = 4; iv = 1; ordy = 0;
    step();
    sel = {1'b0, OP_SUB}; x = 9; y = 1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stall%0d valid", k), ov, 1);
      chk($sformatf("stall%0d result", k), res, 7);
      chk($sformatf("stall%0d in_ready", k), ir, 0);
      step();
    end
    ordy = 1;
    #1;
    chk("release in_ready", ir, 1);
    step();
    chk("release next result", res, 8);
    chk("release next valid", ov, 1);
    sel = {1'b0, OP_ADD}; y = 100;
    for (int k = 0; k < 8; k++) begin
      x = k;
      step();
      chk($sformatf("b2b%0d valid", k), ov, 1);
      chk($sformatf("b2b%0d result", k), res, 100 + k);
    end
    iv = 0;
    step();
    chk("b2b drained", ov, 0);

    // XLEN=64 regression: directed corners plus random operands vs model
    ops = '{5'b00000, 5'b01000, 5'b00001, 5'b00010, 5'b00011, 5'b00100,
            5'b00101, 5'b01101, 5'b00110, 5'b00111, 5'b01111, 5'b01011};
    if (MD) for (int k = 0; k < 8; k++) ops.push_back(5'b10000 | 5'(k));
    for (int k = 0; k < 40; k++) begin
      case (k)
        0: begin s = 5'b00000; a6 = 10; b6 = 20; end
        1: begin s = 5'b01101; a6 = -64'sd16; b6 = 1; end
        2: begin s = 5'b00011; a6 = 1; b6 = '1; end
        3: begin s = MD ? 5'b10011 : 5'b01111; a6 = '1; b6 = '1; end
        4: begin s = MD ? 5'b10100 : 5'b01111; a6 = 64'h8000_0000_0000_0000; b6 = '1; end
        5: begin s = MD ? 5'b10110 : 5'b10110; a6 = 7; b6 = 0; end
        default: begin
          s  = ops[$urandom_range(0, ops.size() - 1)];
          a6 = {$urandom, $urandom};
          b6 = {$urandom, $urandom};
          if (k % 5 == 0) b6 = 64'($urandom_range(0, 9));
        end
      endcase
      m = model64(s, a6, b6);
      run64(s, a6, b6, r6, il6, lat);
      chk($sformatf("x64 #%0d sel=%b result", k, s), r6, m[63:0]);
      chk($sformatf("x64 #%0d illegal", k), il6, m[64]);
      chk($sformatf("x64 #%0d latency", k), lat, (MD && s[4]) ? 65 : 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
